// File: rtl/trap_controller.sv
// Machine-mode trap controller: arbitrates pipeline trap requests, owns the M-mode trap CSRs and
// issues a one-cycle PC redirect. Optional vectored mtvec mode is enabled by defining TRAP_VECTORED_EN.
package trap_pkg;
  typedef enum logic {TRAP_ENTER = 1'b0, TRAP_RETURN = 1'b1} trap_mode_e;

  typedef struct packed {
    logic        valid;
    trap_mode_e  mode;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rediraddr;
  } trap_res_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
endpackage

module trap_controller
  import trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter int          VEC_CAUSE_W = 6
) (
  input  logic        clk,
  input  logic        start,
  input  trap_req_t   trap_req_f,
  input  trap_req_t   trap_req_d,
  input  trap_req_t   trap_req_e,
  input  trap_req_t   trap_req_m,
  output trap_res_t   trap_res,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  typedef enum logic {ST_IDLE = 1'b0, ST_REDIR = 1'b1} state_e;

  state_e      state_r, next_state_s;
  trap_req_t   win_s;
  logic        accept_s;
  logic [31:0] target_s, trap_base_s, enter_target_s;
  trap_res_t   trap_res_r;
  logic [31:2] mtvec_r;
  logic [31:0] mepc_r, mcause_r, mtval_r;
  logic        mie_r, mpie_r;
  logic [1:0]  mtvec_mode_s;

  assign trap_base_s = {mtvec_r, 2'b00};
  assign trap_res    = trap_res_r;

`ifdef TRAP_VECTORED_EN
  logic mtvec_m0_r;
  assign mtvec_mode_s = {1'b0, mtvec_m0_r};

  // Vectored entry offsets the base by the low cause bits, word-aligned.
  always_comb begin
    enter_target_s = trap_base_s;
    if (mtvec_m0_r) begin
      enter_target_s = trap_base_s +
        {{(30 - VEC_CAUSE_W){1'b0}}, win_s.cause[VEC_CAUSE_W-1:0], 2'b00};
    end else begin
      enter_target_s = trap_base_s;
    end
  end
`else
  logic cfg_unused_s;
  assign cfg_unused_s   = (VEC_CAUSE_W > 0);
  assign mtvec_mode_s   = 2'b00;
  assign enter_target_s = trap_base_s;
`endif

  // Fixed-priority arbitration (oldest stage wins) and FSM next-state.
  always_comb begin
    win_s        = trap_req_f;
    next_state_s = state_r;
    accept_s     = 1'b0;
    target_s     = enter_target_s;
    if (trap_req_m.valid) begin
      win_s = trap_req_m;
    end else if (trap_req_e.valid) begin
      win_s = trap_req_e;
    end else if (trap_req_d.valid) begin
      win_s = trap_req_d;
    end else begin
      win_s = trap_req_f;
    end
    case (state_r)
      ST_IDLE: begin
        if (win_s.valid) begin
          accept_s     = 1'b1;
          next_state_s = ST_REDIR;
          if (win_s.mode == TRAP_RETURN) begin
            target_s = mepc_r;
          end else begin
            target_s = enter_target_s;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REDIR: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // State register and registered redirect output.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_r    <= ST_IDLE;
      trap_res_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        trap_res_r <= {1'b1, target_s};
      end else begin
        trap_res_r <= '0;
      end
    end
  end

  // CSR state: a trap accept takes precedence over a same-cycle CSR write.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      mtvec_r  <= RESET_MTVEC[31:2];
`ifdef TRAP_VECTORED_EN
      mtvec_m0_r <= RESET_MTVEC[0];
`endif
      mepc_r   <= 32'h0000_0000;
      mcause_r <= 32'h0000_0000;
      mtval_r  <= 32'h0000_0000;
      mie_r    <= 1'b0;
      mpie_r   <= 1'b0;
    end else if (accept_s && (win_s.mode == TRAP_ENTER)) begin
      mepc_r   <= win_s.pc;
      mcause_r <= win_s.cause;
      mtval_r  <= win_s.tval;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (accept_s) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_r  <= csr_wdata[3];
          mpie_r <= csr_wdata[7];
        end
        CSR_MTVEC: begin
          mtvec_r <= csr_wdata[31:2];
`ifdef TRAP_VECTORED_EN
          mtvec_m0_r <= csr_wdata[0];
`endif
        end
        CSR_MEPC:   mepc_r   <= {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE: mcause_r <= csr_wdata;
        CSR_MTVAL:  mtval_r  <= csr_wdata;
        default:    mcause_r <= mcause_r;
      endcase
    end else begin
      mie_r <= mie_r;
    end
  end

  // Combinational CSR read of pre-edge state; MPP is hardwired to M-mode.
  always_comb begin
    csr_rdata = 32'h0000_0000;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b000, mpie_r, 3'b000, mie_r, 3'b000};
      CSR_MTVEC:   csr_rdata = {mtvec_r, mtvec_mode_s};
      CSR_MEPC:    csr_rdata = mepc_r;
      CSR_MCAUSE:  csr_rdata = mcause_r;
      CSR_MTVAL:   csr_rdata = mtval_r;
      default:     csr_rdata = 32'h0000_0000;
    endcase
  end

endmodule
